// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory among N requesters with a request/ack handshake.
module mem_port_arbiter #(
    parameter int N_PORTS = 2,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int RR_MODE = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_PORTS-1:0]        req,
    input  logic [N_PORTS-1:0]        we,
    input  logic [N_PORTS*ADDR_W-1:0] addr,
    input  logic [N_PORTS*DATA_W-1:0] wdata,
    input  logic [N_PORTS*2-1:0]      size,
    input  logic [N_PORTS-1:0]        sgn,
    output logic [N_PORTS-1:0]        ack,
    output logic [N_PORTS-1:0]        err,
    output logic [N_PORTS-1:0]        stall,
    output logic [DATA_W-1:0]         rdata,
    output logic                      m_en,
    output logic                      m_we,
    output logic [ADDR_W-1:0]         m_addr,
    output logic [DATA_W-1:0]         m_wdata,
    output logic [1:0]                m_size,
    input  logic [DATA_W-1:0]         m_rdata
);
    localparam int PW = $clog2(N_PORTS);
    localparam int CW = $clog2(MEM_LAT + 1);
    typedef enum logic [1:0] {IDLE, CHECK, WAIT} state_t;
    state_t             state;
    logic [PW-1:0]      ptr, win, lwin;
    logic               found, bad, lwe, lsgn;
    logic [CW-1:0]      cnt;
    logic [1:0]         lsize, s_size;
    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_wdata, wmask, ext;
    logic [N_PORTS-1:0] oh, loh;
    int                 idx;
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 1; k <= N_PORTS; k++) begin
            idx = ((RR_MODE != 0 ? int'(ptr) : N_PORTS - 1) + k) % N_PORTS;
            if (!found && req[idx]) begin
                win = PW'(idx);
                found = 1'b1;
            end
        end
    end
    assign s_addr  = addr[win*ADDR_W +: ADDR_W];
    assign s_size  = size[win*2 +: 2];
    assign s_wdata = wdata[win*DATA_W +: DATA_W];
    assign bad     = s_size == 2'b11 || (s_size == 2'b01 && s_addr[0]) || (s_size == 2'b10 && s_addr[1:0] != 2'b00);
    assign wmask   = s_size == 2'b00 ? DATA_W'(8'hFF) : s_size == 2'b01 ? DATA_W'(16'hFFFF) : '1;
    assign oh      = N_PORTS'(1) << win;
    assign loh     = N_PORTS'(1) << lwin;
    assign ext     = lsize == 2'b00 ? {{(DATA_W-8){lsgn & m_rdata[7]}}, m_rdata[7:0]}
                   : lsize == 2'b01 ? {{(DATA_W-16){lsgn & m_rdata[15]}}, m_rdata[15:0]} : m_rdata;
    assign rdata   = (|ack && !lwe) ? ext : '0;
    assign stall   = req & ~ack & ~err;
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= PW'(N_PORTS - 1);
            lwin    <= '0;
            cnt     <= '0;
            ack     <= '0;
            err     <= '0;
            m_en    <= 1'b0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            m_size  <= '0;
            lwe     <= 1'b0;
            lsgn    <= 1'b0;
            lsize   <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    // outputs are registered one cycle ahead so the checked access shows up during CHECK
                    state   <= CHECK;
                    ptr     <= win;
                    lwin    <= win;
                    lwe     <= we[win];
                    lsgn    <= sgn[win];
                    lsize   <= s_size;
                    m_addr  <= s_addr;
                    m_wdata <= s_wdata & wmask;
                    m_size  <= s_size;
                    m_en    <= !bad;
                    m_we    <= we[win] && !bad;
                    err     <= bad ? oh : '0;
                    ack     <= (!bad && we[win]) ? oh : '0;
                end
                CHECK: begin
                    m_en  <= 1'b0;
                    m_we  <= 1'b0;
                    err   <= '0;
                    state <= (m_en && !m_we) ? WAIT : IDLE;
                    cnt   <= CW'(MEM_LAT - 1);
                    ack   <= (m_en && !m_we && MEM_LAT == 1) ? loh : '0;
                end
                WAIT: begin
                    state <= cnt == '0 ? IDLE : WAIT;
                    cnt   <= cnt == '0 ? cnt : cnt - CW'(1);
                    ack   <= cnt == CW'(1) ? loh : '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: fixed-priority (latency 2) and round-robin (latency 3) instances against a behavioural model.
module tb_mem_port_arbiter;
    localparam int LAT_A = 2;
    localparam int LAT_B = 3;
    logic        clk = 1'b0, rst = 1'b0, sel = 1'b0;
    logic [1:0]  req = '0, we = '0, sgn = '0;
    logic [15:0] addr = '0;
    logic [63:0] wdata = '0;
    logic [3:0]  size = '0;
    logic [1:0]  req_a, req_b, ack_a, ack_b, err_a, err_b, stall_a, stall_b;
    logic [31:0] rdata_a, rdata_b, m_wdata_a, m_wdata_b, m_rdata_a, m_rdata_b;
    logic        m_en_a, m_en_b, m_we_a, m_we_b;
    logic [7:0]  m_addr_a, m_addr_b, ra_a, ra_b;
    logic [1:0]  m_size_a, m_size_b;
    logic [1:0]  o_ack, o_err, o_stall, o_m_size;
    logic [31:0] o_rdata, o_m_wdata;
    logic [7:0]  o_m_addr;
    logic        o_m_en, o_m_we;
    logic [31:0] mword [256];
    int          cnt_a = 0, cnt_b = 0;
    int          checks = 0, failures = 0;
    int          r_lat, r_men, r_sbad;
    logic [1:0]  r_av, r_ev, r_ms;
    logic [31:0] r_rd, r_mw;
    logic [7:0]  r_ma;
    logic        r_mwe;

    always #5 clk = ~clk;
    assign req_a = sel ? 2'b00 : req;
    assign req_b = sel ? req : 2'b00;
    assign o_ack = sel ? ack_b : ack_a;
    assign o_err = sel ? err_b : err_a;
    assign o_stall = sel ? stall_b : stall_a;
    assign o_rdata = sel ? rdata_b : rdata_a;
    assign o_m_en = sel ? m_en_b : m_en_a;
    assign o_m_we = sel ? m_we_b : m_we_a;
    assign o_m_addr = sel ? m_addr_b : m_addr_a;
    assign o_m_wdata = sel ? m_wdata_b : m_wdata_a;
    assign o_m_size = sel ? m_size_b : m_size_a;

    mem_port_arbiter #(.N_PORTS(2), .ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT_A), .RR_MODE(0)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .we(we), .addr(addr), .wdata(wdata), .size(size), .sgn(sgn),
        .ack(ack_a), .err(err_a), .stall(stall_a), .rdata(rdata_a), .m_en(m_en_a), .m_we(m_we_a),
        .m_addr(m_addr_a), .m_wdata(m_wdata_a), .m_size(m_size_a), .m_rdata(m_rdata_a));
    mem_port_arbiter #(.N_PORTS(2), .ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT_B), .RR_MODE(1)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .we(we), .addr(addr), .wdata(wdata), .size(size), .sgn(sgn),
        .ack(ack_b), .err(err_b), .stall(stall_b), .rdata(rdata_b), .m_en(m_en_b), .m_we(m_we_b),
        .m_addr(m_addr_b), .m_wdata(m_wdata_b), .m_size(m_size_b), .m_rdata(m_rdata_b));

    // memory presents data only in the single cycle MEM_LAT after the strobe, garbage otherwise
    always @(posedge clk) begin
        if (m_en_a && !m_we_a) begin cnt_a <= LAT_A; ra_a <= m_addr_a; end
        else if (cnt_a != 0) cnt_a <= cnt_a - 1;
        if (m_en_b && !m_we_b) begin cnt_b <= LAT_B; ra_b <= m_addr_b; end
        else if (cnt_b != 0) cnt_b <= cnt_b - 1;
    end
    assign m_rdata_a = cnt_a == 1 ? mword[ra_a] : 32'hA5A5A5A5;
    assign m_rdata_b = cnt_b == 1 ? mword[ra_b] : 32'hA5A5A5A5;

    function automatic logic bad_f(input logic [1:0] sz, input logic [7:0] a);
        return sz == 2'd3 || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd2 && a % 4 != 0);
    endfunction
    function automatic logic [31:0] ext_f(input logic [31:0] v, input logic [1:0] sz, input logic s);
        int x;
        if (sz == 2'd2) return v;
        x = sz == 2'd0 ? int'(v % 256) : int'(v % 65536);
        if (s && x >= (sz == 2'd0 ? 128 : 32768)) x -= (sz == 2'd0 ? 256 : 65536);
        return 32'(x);
    endfunction
    function automatic logic [31:0] mask_f(input logic [31:0] v, input logic [1:0] sz);
        return sz == 2'd0 ? v % 256 : sz == 2'd1 ? v % 65536 : v;
    endfunction

    task automatic set_port(input int p, input logic w, input logic [7:0] a, input logic [31:0] wd, input logic [1:0] sz, input logic sg);
        we[p] = w; addr[p*8 +: 8] = a; wdata[p*32 +: 32] = wd; size[p*2 +: 2] = sz; sgn[p] = sg;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b0; req = '0;
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic run_one(input logic [1:0] rm);
        r_lat = -1; r_av = '0; r_ev = '0; r_rd = '0; r_men = 0; r_ma = '0; r_mw = '0; r_ms = '0; r_mwe = 1'b0; r_sbad = 0;
        @(posedge clk); #1 req = rm;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_stall !== (req & ~o_ack & ~o_err)) r_sbad++;
            if (o_m_en) begin r_men++; r_ma = o_m_addr; r_mw = o_m_wdata; r_ms = o_m_size; r_mwe = o_m_we; end
            if (o_ack != 0 || o_err != 0) begin r_lat = c; r_av = o_ack; r_ev = o_err; r_rd = o_rdata; break; end
        end
        @(posedge clk); #1 req = '0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        set_port(0, 1'b0, 8'h40, 32'h0, 2'd2, 1'b0);
        set_port(1, 1'b0, 8'h44, 32'h0, 2'd2, 1'b0);
        rst = 1'b0; req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL reset_ack cyc=%0d got=%b exp=00", i, o_ack); end
            checks++; if (o_err !== 2'b00) begin failures++; $display("FAIL reset_err cyc=%0d got=%b exp=00", i, o_err); end
            checks++; if (o_m_en !== 1'b0) begin failures++; $display("FAIL reset_m_en cyc=%0d got=%b exp=0", i, o_m_en); end
        end
        checks++; if (o_rdata !== 32'h0 || o_m_addr !== 8'h0) begin failures++; $display("FAIL reset_regs rdata=%h m_addr=%h exp=0", o_rdata, o_m_addr); end
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (o_m_en !== 1'b0) begin failures++; $display("FAIL release_c0_m_en got=%b exp=0", o_m_en); end
        @(negedge clk);
        checks++; if (o_m_en !== 1'b1) begin failures++; $display("FAIL release_c1_m_en got=%b exp=1", o_m_en); end
        checks++; if (o_m_addr !== 8'h40) begin failures++; $display("FAIL release_m_addr got=%h exp=40", o_m_addr); end
        checks++; if (o_stall !== 2'b11) begin failures++; $display("FAIL release_stall got=%b exp=11", o_stall); end
        do_reset();
    endtask

    task automatic test_word_read();
        sel = 1'b0;
        mword[8'h10] = 32'hDEADBEEF;
        set_port(1, 1'b0, 8'h10, 32'h0, 2'd2, 1'b0);
        run_one(2'b10);
        checks++; if (r_lat !== 1 + LAT_A) begin failures++; $display("FAIL word_read_lat got=%0d exp=%0d", r_lat, 1 + LAT_A); end
        checks++; if (r_av !== 2'b10 || r_ev !== 2'b00) begin failures++; $display("FAIL word_read_ack got=%b/%b exp=10/00", r_av, r_ev); end
        checks++; if (r_rd !== 32'hDEADBEEF) begin failures++; $display("FAIL word_read_rdata got=%h exp=deadbeef", r_rd); end
        checks++; if (r_sbad !== 0) begin failures++; $display("FAIL word_read_stall bad_cycles=%0d exp=0", r_sbad); end
        checks++; if (r_men !== 1 || r_ma !== 8'h10 || r_ms !== 2'd2 || r_mwe !== 1'b0) begin
            failures++; $display("FAIL word_read_mem en=%0d addr=%h size=%0d we=%b exp=1/10/2/0", r_men, r_ma, r_ms, r_mwe); end
    endtask

    task automatic test_extend();
        logic [7:0]  ta [3] = '{8'h31, 8'h31, 8'h32};
        logic [1:0]  ts [3] = '{2'd0, 2'd0, 2'd1};
        logic        tg [3] = '{1'b1, 1'b0, 1'b1};
        logic [31:0] tm [3] = '{32'h00000080, 32'h00000080, 32'h00008001};
        logic [31:0] te [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8001};
        sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mword[ta[i]] = tm[i];
            set_port(0, 1'b0, ta[i], 32'h0, ts[i], tg[i]);
            run_one(2'b01);
            checks++; if (r_av !== 2'b01 || r_lat !== 1 + LAT_A) begin failures++; $display("FAIL extend_ack%0d got=%b@%0d exp=01@%0d", i, r_av, r_lat, 1 + LAT_A); end
            checks++; if (r_rd !== te[i]) begin failures++; $display("FAIL extend_rdata%0d got=%h exp=%h", i, r_rd, te[i]); end
        end
    endtask

    task automatic test_contention();
        for (int s = 0; s < 2; s++) begin
            int n = 0, prev = 0, g, eg, lat;
            sel = s[0];
            lat = s == 1 ? LAT_B : LAT_A;
            do_reset();
            mword[0] = $urandom; mword[4] = $urandom;
            set_port(0, 1'b0, 8'h00, 32'h0, 2'd2, 1'b0);
            set_port(1, 1'b0, 8'h04, 32'h0, 2'd2, 1'b1);
            @(posedge clk); #1 req = 2'b11;
            for (int c = 0; c < 60 && n < 4; c++) begin
                @(negedge clk);
                if (o_ack != 0) begin
                    g = o_ack == 2'b01 ? 0 : o_ack == 2'b10 ? 1 : -1;
                    eg = s == 1 ? n % 2 : 0;
                    checks++; if (g !== eg) begin failures++; $display("FAIL contention_grant mode=%0d n=%0d got=%0d exp=%0d", s, n, g, eg); end
                    checks++; if (o_rdata !== mword[eg*4]) begin failures++; $display("FAIL contention_rdata mode=%0d n=%0d got=%h exp=%h", s, n, o_rdata, mword[eg*4]); end
                    checks++; if (c - prev !== (n == 0 ? 1 + lat : 2 + lat)) begin
                        failures++; $display("FAIL contention_gap mode=%0d n=%0d got=%0d exp=%0d", s, n, c - prev, n == 0 ? 1 + lat : 2 + lat); end
                    prev = c;
                    n++;
                end
            end
            checks++; if (n !== 4) begin failures++; $display("FAIL contention_count mode=%0d got=%0d exp=4", s, n); end
            @(posedge clk); #1 req = '0;
        end
    endtask

    task automatic test_misaligned();
        logic [7:0]  ta [5] = '{8'h06, 8'h06, 8'h00, 8'h05, 8'h08};
        logic [1:0]  ts [5] = '{2'd2, 2'd1, 2'd3, 2'd1, 2'd2};
        logic        tb [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        logic [31:0] te [5] = '{32'h0, 32'h00009001, 32'h0, 32'h0, 32'h01234567};
        sel = 1'b0;
        mword[8'h06] = 32'hCAFE9001; mword[8'h08] = 32'h01234567;
        for (int i = 0; i < 5; i++) begin
            set_port(0, 1'b0, ta[i], 32'h0, ts[i], 1'b0);
            run_one(2'b01);
            if (tb[i]) begin
                checks++; if (r_lat !== 1 || r_ev !== 2'b01 || r_av !== 2'b00) begin
                    failures++; $display("FAIL misaligned_err%0d got=err%b ack%b @%0d exp=err01 ack00 @1", i, r_ev, r_av, r_lat); end
                checks++; if (r_men !== 0) begin failures++; $display("FAIL misaligned_m_en%0d got=%0d exp=0", i, r_men); end
            end else begin
                checks++; if (r_lat !== 1 + LAT_A || r_av !== 2'b01 || r_ev !== 2'b00) begin
                    failures++; $display("FAIL aligned_ack%0d got=ack%b err%b @%0d exp=ack01 err00 @%0d", i, r_av, r_ev, r_lat, 1 + LAT_A); end
                checks++; if (r_rd !== te[i]) begin failures++; $display("FAIL aligned_rdata%0d got=%h exp=%h", i, r_rd, te[i]); end
            end
        end
    endtask

    task automatic test_write_reset();
        int lat = -1;
        logic [1:0] av = '0;
        logic [31:0] rd = '0;
        sel = 1'b1;
        set_port(0, 1'b1, 8'h20, 32'h12345678, 2'd2, 1'b0);
        run_one(2'b01);
        checks++; if (r_lat !== 1 || r_av !== 2'b01) begin failures++; $display("FAIL write_ack got=%b@%0d exp=01@1", r_av, r_lat); end
        checks++; if (r_men !== 1 || r_mwe !== 1'b1 || r_ma !== 8'h20 || r_mw !== 32'h12345678 || r_ms !== 2'd2) begin
            failures++; $display("FAIL write_mem en=%0d we=%b addr=%h data=%h size=%0d exp=1/1/20/12345678/2", r_men, r_mwe, r_ma, r_mw, r_ms); end
        set_port(0, 1'b1, 8'h23, 32'hAABBCCDD, 2'd0, 1'b0);
        run_one(2'b01);
        checks++; if (r_mw !== 32'h000000DD || r_av !== 2'b01) begin failures++; $display("FAIL byte_write got=%h ack=%b exp=000000dd ack=01", r_mw, r_av); end
        mword[8'h24] = $urandom;
        set_port(1, 1'b0, 8'h24, 32'h0, 2'd2, 1'b0);
        @(posedge clk); #1 req = 2'b10;
        @(posedge clk); #1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (o_ack !== 2'b00) begin failures++; $display("FAIL reset_mid_read_ack got=%b exp=00", o_ack); end
        @(posedge clk); #1 rst = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (o_ack != 0) begin lat = c; av = o_ack; rd = o_rdata; break; end
        end
        @(posedge clk); #1 req = '0;
        checks++; if (lat !== 1 + LAT_B || av !== 2'b10) begin failures++; $display("FAIL regrant_after_reset got=%b@%0d exp=10@%0d", av, lat, 1 + LAT_B); end
        checks++; if (rd !== mword[8'h24]) begin failures++; $display("FAIL regrant_rdata got=%h exp=%h", rd, mword[8'h24]); end
    endtask

    task automatic test_random();
        int last_b = 1;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            logic        w [2];
            logic [7:0]  a [2];
            logic [31:0] wd [2];
            logic [1:0]  sz [2];
            logic        sg [2];
            logic [1:0]  rm, oh;
            int          wp, s, lat_e;
            logic        b;
            s = $urandom_range(0, 1);
            sel = s[0];
            for (int p = 0; p < 2; p++) begin
                w[p] = 1'($urandom_range(0, 1)); sz[p] = 2'($urandom_range(0, 3)); sg[p] = 1'($urandom_range(0, 1));
                wd[p] = $urandom; a[p] = 8'($urandom);
                if ($urandom_range(0, 3) != 0) a[p] = a[p] - a[p] % (sz[p] == 2'd2 ? 8'd4 : sz[p] == 2'd1 ? 8'd2 : 8'd1);
                mword[a[p]] = $urandom;
                set_port(p, w[p], a[p], wd[p], sz[p], sg[p]);
            end
            rm = 2'($urandom_range(1, 3));
            if (s == 0) wp = rm[0] ? 0 : 1;
            else begin
                wp = rm[(last_b + 1) % 2] ? (last_b + 1) % 2 : last_b;
                last_b = wp;
            end
            b = bad_f(sz[wp], a[wp]);
            oh = 2'(1 << wp);
            lat_e = (b || w[wp]) ? 1 : 1 + (s == 1 ? LAT_B : LAT_A);
            run_one(rm);
            checks++; if (r_lat !== lat_e) begin failures++; $display("FAIL rand_lat it=%0d got=%0d exp=%0d", it, r_lat, lat_e); end
            checks++; if (r_av !== (b ? 2'b00 : oh) || r_ev !== (b ? oh : 2'b00)) begin
                failures++; $display("FAIL rand_resp it=%0d got=ack%b err%b exp=ack%b err%b", it, r_av, r_ev, b ? 2'b00 : oh, b ? oh : 2'b00); end
            checks++; if (r_sbad !== 0) begin failures++; $display("FAIL rand_stall it=%0d bad_cycles=%0d exp=0", it, r_sbad); end
            checks++; if (r_men !== (b ? 0 : 1)) begin failures++; $display("FAIL rand_m_en it=%0d got=%0d exp=%0d", it, r_men, b ? 0 : 1); end
            if (!b) begin
                checks++; if (r_ma !== a[wp] || r_ms !== sz[wp] || r_mwe !== w[wp] || r_mw !== mask_f(wd[wp], sz[wp])) begin
                    failures++; $display("FAIL rand_mem it=%0d got=%h/%0d/%b/%h exp=%h/%0d/%b/%h", it, r_ma, r_ms, r_mwe, r_mw, a[wp], sz[wp], w[wp], mask_f(wd[wp], sz[wp])); end
                if (!w[wp]) begin
                    checks++; if (r_rd !== ext_f(mword[a[wp]], sz[wp], sg[wp])) begin
                        failures++; $display("FAIL rand_rdata it=%0d got=%h exp=%h", it, r_rd, ext_f(mword[a[wp]], sz[wp], sg[wp])); end
                end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_word_read();
        test_extend();
        test_contention();
        test_misaligned();
        test_write_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
